// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the 5-stage pipeline controller.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  // Per-stage hold vectors: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;  // hold front end, bubble into EX
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;  // hold through EX, bubble into MEM

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_EXWAIT = 2'd1,
    S_FLUSH  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges ID load-use stalls, EX multi-cycle stalls and
// flush requests into a per-stage stall vector, a flush strobe with redirect
// PC, and a saturating stalled-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_multi_start,
  input  logic [CNT_W-1:0]   ex_multi_cycles,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               ex_busy,
  output logic [PERF_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0]  CNT_THREE = CNT_W'(3);
  localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

  ctrl_state_e      state;
  ctrl_state_e      state_next;
  logic [CNT_W-1:0] cnt;

  // An op of length N>=2 started from S_RUN stalls EX; N>=3 needs the wait state.
  logic multi_go;
  logic long_op;

  assign multi_go = (state == S_RUN) && ex_multi_start && (ex_multi_cycles >= CNT_TWO);
  assign long_op  = multi_go && (ex_multi_cycles >= CNT_THREE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Next-state logic; a flush request overrides every other transition.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves the
    // variable unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      S_RUN:    if (long_op) state_next = S_EXWAIT;
      S_EXWAIT: if (cnt <= CNT_ONE) state_next = S_RUN;
      S_FLUSH:  state_next = S_RUN;
      default:  state_next = S_RUN;
    endcase
    if (flush_req) state_next = S_FLUSH;
  end

  // Output decode: flush outranks EX stall, EX stall outranks ID stall.
  always_comb begin
    stall   = STALL_NONE;
    ex_busy = 1'b0;
    if (!rst) begin
      ex_busy = (state == S_EXWAIT) || multi_go;
      if (flush_req || (state == S_FLUSH))  stall = STALL_NONE;
      else if (ex_busy)                     stall = STALL_EX;
      else if (stallreq_id)                 stall = STALL_ID;
      else                                  stall = STALL_NONE;
    end
  end

  // EX wait downcounter: loaded with N-2 so S_EXWAIT plus the start cycle give N-1 stalls.
  always_ff @(posedge clk) begin
    if (rst || flush_req)        cnt <= '0;
    else if (long_op)            cnt <= ex_multi_cycles - CNT_TWO;
    else if (state == S_EXWAIT)  cnt <= cnt - CNT_ONE;
  end

  // Flush strobe and redirect target, one cycle after each flush_req cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush  <= 1'b0;
      new_pc <= ZERO_WORD;
    end else begin
      flush <= flush_req;
      if (flush_req) new_pc <= flush_pc;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst)                                      stall_cycles <= '0;
    else if (stall[0] && (stall_cycles != PERF_MAX)) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues directed then random
// stimulus and pushes the expected outputs from a stall-budget model; a
// negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int CNT_W  = 6;
  localparam int PERF_W = 8;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_id;
  logic              ex_multi_start;
  logic [CNT_W-1:0]  ex_multi_cycles;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              ex_busy;
  logic [PERF_W-1:0] stall_cycles;

  pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id     (stallreq_id),
    .ex_multi_start  (ex_multi_start),
    .ex_multi_cycles (ex_multi_cycles),
    .flush_req       (flush_req),
    .flush_pc        (flush_pc),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .ex_busy         (ex_busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          regs_known;
    logic [5:0]  stall;
    logic        ex_busy;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] perf;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: remaining EX stall cycles, pending flush, redirect PC, perf count.
  int          m_left     = 0;
  bit          m_flushing = 1'b0;
  logic [31:0] m_pc       = '0;
  int          m_perf     = 0;
  bit          m_known    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expected outputs for that cycle go to the scoreboard.
  task automatic drive(input bit r, input bit id, input bit st, input int n,
                       input bit fr, input logic [31:0] pc);
    exp_t e;
    bit   start_eff;
    @(posedge clk);
    #1;
    rst             = r;
    stallreq_id     = id;
    ex_multi_start  = st;
    ex_multi_cycles = n[CNT_W-1:0];
    flush_req       = fr;
    flush_pc        = pc;

    start_eff    = !m_flushing && (m_left == 0) && st && (n >= 2);
    e.regs_known = m_known;
    e.flush      = m_flushing;
    e.new_pc     = m_pc;
    e.perf       = m_perf;
    if (r) begin
      e.stall   = 6'b000000;
      e.ex_busy = 1'b0;
    end else begin
      e.ex_busy = (m_left > 0) || start_eff;
      if (fr || m_flushing)          e.stall = 6'b000000;
      else if (e.ex_busy)            e.stall = 6'b001111;
      else if (id)                   e.stall = 6'b000111;
      else                           e.stall = 6'b000000;
    end
    sb.push_back(e);

    if (r) begin
      m_left = 0; m_flushing = 1'b0; m_pc = '0; m_perf = 0; m_known = 1'b1;
    end else begin
      if (e.stall[0] && m_perf < PERF_MAX) m_perf++;
      if (fr) begin
        m_flushing = 1'b1;
        m_pc       = pc;
        m_left     = 0;
      end else begin
        m_flushing = 1'b0;
        if (m_left > 0)     m_left--;
        else if (start_eff) m_left = n - 2;  // N-1 stalls total, this cycle is the first
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest expectation, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("stall",   64'(stall),   64'(e.stall));
      check("ex_busy", 64'(ex_busy), 64'(e.ex_busy));
      if (e.regs_known) begin
        check("flush",        64'(flush),        64'(e.flush));
        check("new_pc",       64'(new_pc),       64'(e.new_pc));
        check("stall_cycles", 64'(stall_cycles), 64'(e.perf));
      end
    end
  end

  initial begin
    int r_n;
    rst = 1'b1; stallreq_id = 1'b0; ex_multi_start = 1'b0;
    ex_multi_cycles = '0; flush_req = 1'b0; flush_pc = '0;

    // Reset with conflicting requests asserted.
    drive(1, 1, 0, 0, 1, 32'hdead_beef);
    drive(1, 1, 0, 0, 1, 32'hdead_beef);
    idle(1);

    // Single load-use cycle.
    drive(0, 1, 0, 0, 0, 32'h0);
    idle(2);

    // Multi-cycle ops N=5, N=2, N=1.
    drive(0, 0, 1, 5, 0, 32'h0);
    idle(6);
    drive(0, 0, 1, 2, 0, 32'h0);
    idle(3);
    drive(0, 0, 1, 1, 0, 32'h0);
    idle(2);

    // Flush on the third stall cycle of an N=10 op; start during the wait is ignored.
    drive(0, 0, 1, 10, 0, 32'h0);
    drive(0, 0, 1, 7, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0000_0020);
    idle(4);

    // Priority: ID and EX together, then flush with ID.
    drive(0, 1, 1, 3, 0, 32'h0);
    drive(0, 1, 0, 0, 0, 32'h0);
    idle(2);
    drive(0, 1, 0, 0, 1, 32'h0000_0044);
    idle(2);

    // Held flush_req with changing targets, ID requests ignored meanwhile.
    drive(0, 1, 0, 0, 1, 32'h0000_1000);
    drive(0, 1, 0, 0, 1, 32'h0000_2000);
    drive(0, 1, 1, 4, 1, 32'h0000_3000);
    idle(2);

    // Drive the perf counter into saturation and keep stalling.
    for (int i = 0; i < PERF_MAX + 8; i++) drive(0, 1, 0, 0, 0, 32'h0);
    idle(2);

    // Reset in the middle of a long EX wait and right after a flush.
    drive(0, 0, 1, 20, 0, 32'h0);
    idle(3);
    drive(1, 0, 0, 0, 0, 32'h0);
    idle(3);
    drive(0, 0, 0, 0, 1, 32'h0000_0abc);
    drive(1, 0, 0, 0, 0, 32'h0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r_n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8));
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            r_n,
            ($urandom_range(0, 11) == 0),
            {$urandom_range(0, 32'hffff), 2'b00} << 2);
    end
    idle(3);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
